// File: rtl/mem_byte_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the memory-side byte responder of the
// multicycle MIPS core.
//   state_e      : responder FSM states
//   lane_t       : byte-lane index within a 32-bit word
//   lane_onehot  : lane index -> one-hot byte strobe
//   lane_byte    : lane index -> byte of a word (little-endian)
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;
    localparam int WORD_W         = 32;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        READ_TAIL = 3'd2,
        WRITE     = 3'd3,
        RESP      = 3'd4
    } state_e;

    // One-hot strobe for a byte lane; lane 0 is the least significant byte.
    function automatic logic [BYTES_PER_WORD-1:0] lane_onehot(input lane_t lane);
        logic [BYTES_PER_WORD-1:0] oh;
        case (lane)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Select one byte of a word by lane, little-endian.
    function automatic logic [7:0] lane_byte(input logic [WORD_W-1:0] word, input lane_t lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_byte_responder_if.sv
// -----------------------------------------------------------------------------
// mem_byte_responder_if
// Core-side request/response bundle between the MIPS control/datapath and
// the byte responder.
//   req_i/we_i/addr_i/wdata_i : word request from the core
//   busy_o                    : responder not idle
//   rsp_valid_o/rdata_o       : one-cycle completion pulse and read word
//   byte_we_o                 : one-hot strobe of the byte currently on the RAM
//   align_err_o               : request address was not word aligned
// Modports: master = core, slave = responder.
// -----------------------------------------------------------------------------
interface mem_byte_responder_if;
    import mem_pkg::*;

    logic                      req_i;
    logic                      we_i;
    logic [WORD_W-1:0]         addr_i;
    logic [WORD_W-1:0]         wdata_i;
    logic                      busy_o;
    logic                      rsp_valid_o;
    logic [WORD_W-1:0]         rdata_o;
    logic [BYTES_PER_WORD-1:0] byte_we_o;
    logic                      align_err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  busy_o, rsp_valid_o, rdata_o, byte_we_o, align_err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output busy_o, rsp_valid_o, rdata_o, byte_we_o, align_err_o
    );

endinterface

// File: rtl/mem_byte_responder_byte_word_assembler.sv
// -----------------------------------------------------------------------------
// byte_word_assembler
// Holds a 32-bit word and overwrites the lane(s) selected by a one-hot byte
// strobe with the incoming byte. Used for read data here; the same block
// can assemble the core's instruction register.
//   clk_i, rst_i : clock, asynchronous active-high reset (word clears to 0)
//   lane_we_i    : one-hot byte-lane write strobe
//   byte_i       : byte to insert
//   word_o       : assembled word (registered)
// -----------------------------------------------------------------------------
module byte_word_assembler
    import mem_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [BYTES_PER_WORD-1:0] lane_we_i,
    input  logic [7:0]                byte_i,
    output logic [WORD_W-1:0]         word_o
);

    logic [WORD_W-1:0] word_r;
    logic [WORD_W-1:0] word_nxt_s;

    // Merge the strobed byte into its lane; unstrobed lanes keep their value
    always_comb begin
        word_nxt_s = word_r;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (lane_we_i[k]) begin
                word_nxt_s[8*k +: 8] = byte_i;
            end else begin
                word_nxt_s[8*k +: 8] = word_r[8*k +: 8];
            end
        end
    end

    // Word register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_r <= {WORD_W{1'b0}};
        end else begin
            word_r <= word_nxt_s;
        end
    end

    assign word_o = word_r;

endmodule

// File: rtl/mem_byte_responder.sv
// -----------------------------------------------------------------------------
// mem_byte_responder
// Memory-side responder for the multicycle MIPS core. Each 32-bit word
// request is serialised into four byte accesses (lane 0 first) on a
// byte-wide synchronous RAM with one cycle of read latency.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   core          : core-side request/response interface (slave modport)
//   mem_addr_o    : RAM byte address
//   mem_we_o      : RAM byte write enable
//   mem_wdata_o   : RAM write byte
//   mem_rdata_i   : RAM read byte, valid the cycle after its address
// Read:  IDLE -> READ x4 -> READ_TAIL -> RESP (response 5 edges after accept)
// Write: IDLE -> WRITE x4 -> RESP              (response 4 edges after accept)
// All outputs are registered; next-cycle values are decoded from the state.
// -----------------------------------------------------------------------------
module mem_byte_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_byte_responder_if.slave  core,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_we_o,
    output logic [7:0]           mem_wdata_o,
    input  logic [7:0]           mem_rdata_i
);

    // Word index = RAM byte address without the lane bits.
    localparam int WIDX_W = ADDR_W - 2;

    // The strobe timing below assumes the RAM answers exactly one cycle later.
    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("mem_byte_responder: RD_LAT must be 1");
    end

    state_e                    state_r;
    state_e                    state_nxt_s;
    lane_t                     cnt_r;
    lane_t                     cnt_nxt_s;
    lane_t                     cnt_inc_s;
    logic [WIDX_W-1:0]         widx_r;
    logic [WIDX_W-1:0]         widx_nxt_s;
    logic [WORD_W-1:0]         wdata_r;
    logic [WORD_W-1:0]         wdata_nxt_s;
    logic                      err_r;
    logic                      err_nxt_s;

    logic                      busy_r;
    logic                      busy_nxt_s;
    logic                      rsp_valid_r;
    logic                      rsp_valid_nxt_s;
    logic                      align_err_r;
    logic                      align_err_nxt_s;
    logic [BYTES_PER_WORD-1:0] byte_we_r;
    logic [BYTES_PER_WORD-1:0] byte_we_nxt_s;
    logic [ADDR_W-1:0]         mem_addr_r;
    logic [ADDR_W-1:0]         mem_addr_nxt_s;
    logic                      mem_we_r;
    logic                      mem_we_nxt_s;
    logic [7:0]                mem_wdata_r;
    logic [7:0]                mem_wdata_nxt_s;

    logic [WORD_W-1:0]         rdata_s;
    logic                      unused_addr_s;

    // Address bits beyond the RAM are deliberately ignored.
    assign unused_addr_s = ^core.addr_i[WORD_W-1:ADDR_W];

    assign cnt_inc_s  = cnt_r + 2'd1;
    assign busy_nxt_s = (state_nxt_s != IDLE);

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        widx_nxt_s      = widx_r;
        wdata_nxt_s     = wdata_r;
        err_nxt_s       = err_r;
        byte_we_nxt_s   = 4'b0000;
        rsp_valid_nxt_s = 1'b0;
        align_err_nxt_s = 1'b0;
        mem_addr_nxt_s  = mem_addr_r;
        mem_we_nxt_s    = 1'b0;
        mem_wdata_nxt_s = mem_wdata_r;

        case (state_r)
            IDLE: begin
                if (core.req_i) begin
                    widx_nxt_s     = core.addr_i[ADDR_W-1:2];
                    wdata_nxt_s    = core.wdata_i;
                    err_nxt_s      = |core.addr_i[1:0];
                    cnt_nxt_s      = 2'd0;
                    mem_addr_nxt_s = {core.addr_i[ADDR_W-1:2], 2'b00};
                    if (core.we_i) begin
                        state_nxt_s     = WRITE;
                        mem_we_nxt_s    = 1'b1;
                        mem_wdata_nxt_s = core.wdata_i[7:0];
                    end else begin
                        state_nxt_s = READ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            READ: begin
                // The byte addressed this cycle shows up on mem_rdata_i next
                // cycle, so its strobe is registered alongside.
                byte_we_nxt_s = lane_onehot(cnt_r);
                cnt_nxt_s     = cnt_inc_s;
                if (cnt_r == 2'd3) begin
                    state_nxt_s = READ_TAIL;
                end else begin
                    state_nxt_s    = READ;
                    mem_addr_nxt_s = {widx_r, cnt_inc_s};
                end
            end

            READ_TAIL: begin
                // Lane 3 is captured at the end of this cycle.
                state_nxt_s     = RESP;
                rsp_valid_nxt_s = 1'b1;
                align_err_nxt_s = err_r;
            end

            WRITE: begin
                cnt_nxt_s = cnt_inc_s;
                if (cnt_r == 2'd3) begin
                    state_nxt_s     = RESP;
                    rsp_valid_nxt_s = 1'b1;
                    align_err_nxt_s = err_r;
                end else begin
                    state_nxt_s     = WRITE;
                    mem_we_nxt_s    = 1'b1;
                    mem_addr_nxt_s  = {widx_r, cnt_inc_s};
                    mem_wdata_nxt_s = lane_byte(wdata_r, cnt_inc_s);
                end
            end

            RESP: begin
                state_nxt_s = IDLE;
            end

            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // State, request context and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            widx_r      <= {WIDX_W{1'b0}};
            wdata_r     <= {WORD_W{1'b0}};
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            align_err_r <= 1'b0;
            byte_we_r   <= 4'b0000;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'h00;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            widx_r      <= widx_nxt_s;
            wdata_r     <= wdata_nxt_s;
            err_r       <= err_nxt_s;
            busy_r      <= busy_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            align_err_r <= align_err_nxt_s;
            byte_we_r   <= byte_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
        end
    end

    // Read bytes land in their lane at the end of their strobe cycle.
    byte_word_assembler u_rdata_asm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .lane_we_i (byte_we_r),
        .byte_i    (mem_rdata_i),
        .word_o    (rdata_s)
    );

    assign core.busy_o      = busy_r;
    assign core.rsp_valid_o = rsp_valid_r;
    assign core.align_err_o = align_err_r;
    assign core.byte_we_o   = byte_we_r;
    assign core.rdata_o     = rdata_s;
    assign mem_addr_o       = mem_addr_r;
    assign mem_we_o         = mem_we_r;
    assign mem_wdata_o      = mem_wdata_r;

endmodule

// File: tb/tb_mem_byte_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_byte_responder
// Bench for mem_byte_responder with a behavioural byte RAM (1-cycle read).
// Expected responses are queued when a request is driven and popped when
// rsp_valid_o is seen.
// -----------------------------------------------------------------------------
module tb_mem_byte_responder;

    localparam int ADDR_W = 8;
    localparam int NTR    = 12;

    typedef struct packed {
        logic [31:0] rdata;
        logic        aerr;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic [7:0]        ram [256];
    logic              ld_en   = 1'b0;
    logic [7:0]        ld_addr = 8'h00;
    logic [7:0]        ld_data = 8'h00;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t exp;
    logic [31:0] last_rd;

    logic [3:0]  tr_bwe   [NTR];
    logic [7:0]  tr_addr  [NTR];
    logic        tr_we    [NTR];
    logic [7:0]  tr_wdata [NTR];
    logic        tr_busy  [NTR];
    int          rsp_edge;
    logic [31:0] obs_rdata;
    logic        obs_aerr;

    mem_byte_responder_if core_if ();

    mem_byte_responder #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .core        (core_if),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk_i = ~clk_i;

    // Byte RAM: synchronous write, one-cycle registered read; bench preload port
    always @(posedge clk_i) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic load_word(input logic [7:0] base, input logic [31:0] word);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            ld_en   = 1'b1;
            ld_addr = base + 8'(k);
            ld_data = word[8*k +: 8];
        end
        @(negedge clk_i);
        ld_en = 1'b0;
    endtask

    // Issue one request and record per-cycle outputs until the response
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        for (int e = 0; e < NTR; e++) begin
            tr_bwe[e] = 4'bxxxx; tr_addr[e] = 8'hxx; tr_we[e] = 1'bx;
            tr_wdata[e] = 8'hxx; tr_busy[e] = 1'bx;
        end
        obs_rdata = 32'hxxxxxxxx;
        obs_aerr  = 1'bx;
        rsp_edge  = -1;
        @(negedge clk_i);
        core_if.req_i   = 1'b1;
        core_if.we_i    = we;
        core_if.addr_i  = addr;
        core_if.wdata_i = wdata;
        @(posedge clk_i);
        #1;
        core_if.req_i   = 1'b0;
        core_if.we_i    = 1'b0;
        core_if.addr_i  = 32'h0;
        core_if.wdata_i = 32'h0;
        for (int e = 0; e < NTR && rsp_edge < 0; e++) begin
            @(negedge clk_i);
            tr_bwe[e]   = core_if.byte_we_o;
            tr_addr[e]  = mem_addr;
            tr_we[e]    = mem_we;
            tr_wdata[e] = mem_wdata;
            tr_busy[e]  = core_if.busy_o;
            if (core_if.rsp_valid_o) begin
                rsp_edge  = e;
                obs_rdata = core_if.rdata_o;
                obs_aerr  = core_if.align_err_o;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({core_if.busy_o, core_if.rsp_valid_o, core_if.align_err_o, core_if.byte_we_o,
             core_if.rdata_o, mem_we, mem_addr, mem_wdata} !== 56'd0)
            begin errors++; $display("FAIL reset_outputs: outputs nonzero during reset, required all 0"); end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({core_if.busy_o, core_if.rsp_valid_o, core_if.byte_we_o, mem_we} !== 7'd0)
            begin errors++; $display("FAIL idle_outputs: busy/rsp/strobe/we nonzero after reset, required 0"); end
    endtask

    task automatic test_read_aligned;
        logic [3:0] eb;
        load_word(8'h10, 32'h12345678);
        exp_q.push_back('{rdata: 32'h12345678, aerr: 1'b0});
        run_txn(1'b0, 32'h10, 32'h0);
        checks++;
        if (rsp_edge != 5) begin errors++; $display("FAIL rd_latency: got %0d want 5", rsp_edge); end
        for (int e = 0; e < 6; e++) begin
            eb = (e >= 1 && e <= 4) ? 4'(1 << (e - 1)) : 4'b0000;
            checks++;
            if (tr_bwe[e] !== eb) begin errors++; $display("FAIL rd_strobe[%0d]: got %b want %b", e, tr_bwe[e], eb); end
            checks++;
            if (tr_we[e] !== 1'b0 || tr_busy[e] !== 1'b1)
                begin errors++; $display("FAIL rd_we_busy[%0d]: got we=%b busy=%b want we=0 busy=1", e, tr_we[e], tr_busy[e]); end
        end
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (tr_addr[e] !== 8'h10 + 8'(e)) begin errors++; $display("FAIL rd_addr[%0d]: got %h want %h", e, tr_addr[e], 8'h10 + 8'(e)); end
        end
        exp = exp_q.pop_front();
        checks++; if (obs_rdata !== exp.rdata) begin errors++; $display("FAIL rd_rdata: got %h want %h", obs_rdata, exp.rdata); end
        checks++; if (obs_aerr !== exp.aerr) begin errors++; $display("FAIL rd_aerr: got %b want %b", obs_aerr, exp.aerr); end
        last_rd = 32'h12345678;
    endtask

    task automatic test_write_then_read;
        logic [31:0] wd;
        wd = 32'hDEADBEEF;
        exp_q.push_back('{rdata: last_rd, aerr: 1'b0});
        run_txn(1'b1, 32'h20, wd);
        checks++;
        if (rsp_edge != 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", rsp_edge); end
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (tr_we[e] !== 1'b1 || tr_addr[e] !== 8'h20 + 8'(e) || tr_wdata[e] !== wd[8*e +: 8])
                begin errors++; $display("FAIL wr_byte[%0d]: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                                         e, tr_we[e], tr_addr[e], tr_wdata[e], 8'h20 + 8'(e), wd[8*e +: 8]); end
        end
        checks++;
        if (tr_we[4] !== 1'b0) begin errors++; $display("FAIL wr_we_resp: got %b want 0", tr_we[4]); end
        checks++;
        if ((tr_bwe[0] | tr_bwe[1] | tr_bwe[2] | tr_bwe[3] | tr_bwe[4]) !== 4'b0000)
            begin errors++; $display("FAIL wr_strobe: byte_we_o active during write, required 0000"); end
        exp = exp_q.pop_front();
        checks++; if (obs_rdata !== exp.rdata) begin errors++; $display("FAIL wr_rdata_hold: got %h want %h", obs_rdata, exp.rdata); end
        checks++; if (obs_aerr !== exp.aerr) begin errors++; $display("FAIL wr_aerr: got %b want %b", obs_aerr, exp.aerr); end
        checks++;
        if ({ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]} !== wd)
            begin errors++; $display("FAIL wr_ram: got %h want %h", {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]}, wd); end
        exp_q.push_back('{rdata: wd, aerr: 1'b0});
        run_txn(1'b0, 32'h20, 32'h0);
        checks++;
        if (rsp_edge != 5) begin errors++; $display("FAIL rdback_latency: got %0d want 5", rsp_edge); end
        exp = exp_q.pop_front();
        checks++; if (obs_rdata !== exp.rdata) begin errors++; $display("FAIL rdback_rdata: got %h want %h", obs_rdata, exp.rdata); end
        last_rd = wd;
    endtask

    task automatic test_misaligned;
        exp_q.push_back('{rdata: 32'hDEADBEEF, aerr: 1'b1});
        run_txn(1'b0, 32'h23, 32'h0);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (tr_addr[e] !== 8'h20 + 8'(e)) begin errors++; $display("FAIL mis_addr[%0d]: got %h want %h", e, tr_addr[e], 8'h20 + 8'(e)); end
        end
        checks++;
        if (rsp_edge != 5) begin errors++; $display("FAIL mis_latency: got %0d want 5", rsp_edge); end
        exp = exp_q.pop_front();
        checks++; if (obs_rdata !== exp.rdata) begin errors++; $display("FAIL mis_rdata: got %h want %h", obs_rdata, exp.rdata); end
        checks++; if (obs_aerr !== exp.aerr) begin errors++; $display("FAIL mis_aerr: got %b want %b", obs_aerr, exp.aerr); end
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_top_of_memory;
        load_word(8'hFC, 32'h44332211);
        exp_q.push_back('{rdata: 32'h44332211, aerr: 1'b0});
        run_txn(1'b0, 32'hFFFFFFFC, 32'h0);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (tr_addr[e] !== 8'hFC + 8'(e)) begin errors++; $display("FAIL top_addr[%0d]: got %h want %h", e, tr_addr[e], 8'hFC + 8'(e)); end
        end
        exp = exp_q.pop_front();
        checks++; if (obs_rdata !== exp.rdata) begin errors++; $display("FAIL top_rdata: got %h want %h", obs_rdata, exp.rdata); end
        checks++; if (obs_aerr !== exp.aerr) begin errors++; $display("FAIL top_aerr: got %b want %b", obs_aerr, exp.aerr); end
        last_rd = 32'h44332211;
    endtask

    // req_i held high: the first read runs alone; the next accept happens
    // only once the FSM is back in IDLE, one cycle after the response.
    task automatic test_busy_ignore;
        int   rsp_cnt;
        int   rsp_a;
        int   rsp_b;
        logic busy_tr [14];
        load_word(8'h00, 32'hD4C3B2A1);
        exp_q.push_back('{rdata: 32'hD4C3B2A1, aerr: 1'b0});
        exp_q.push_back('{rdata: 32'hD4C3B2A1, aerr: 1'b0});
        rsp_cnt = 0; rsp_a = -1; rsp_b = -1;
        @(negedge clk_i);
        core_if.req_i  = 1'b1;
        core_if.we_i   = 1'b0;
        core_if.addr_i = 32'h0;
        for (int e = 0; e < 14; e++) begin
            @(negedge clk_i);
            busy_tr[e] = core_if.busy_o;
            if (core_if.rsp_valid_o) begin
                rsp_cnt++;
                if (rsp_a < 0) rsp_a = e; else rsp_b = e;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL busy_extra_rsp: unexpected response at cycle %0d", e); end
                else begin
                    exp = exp_q.pop_front();
                    if (core_if.rdata_o !== exp.rdata) begin errors++; $display("FAIL busy_rdata: got %h want %h", core_if.rdata_o, exp.rdata); end
                end
            end
        end
        core_if.req_i = 1'b0;
        checks++; if (rsp_cnt != 2) begin errors++; $display("FAIL busy_rsp_count: got %0d want 2", rsp_cnt); end
        checks++; if (rsp_a != 5) begin errors++; $display("FAIL busy_first_rsp: got %0d want 5", rsp_a); end
        checks++; if (rsp_b != 12) begin errors++; $display("FAIL busy_second_rsp: got %0d want 12", rsp_b); end
        for (int e = 0; e < 14; e++) begin
            checks++;
            if (busy_tr[e] !== ((e != 6) && (e != 13)))
                begin errors++; $display("FAIL busy_trace[%0d]: got %b want %b", e, busy_tr[e], (e != 6) && (e != 13)); end
        end
        exp_q.delete();
        @(negedge clk_i);
        last_rd = 32'hD4C3B2A1;
    endtask

    task automatic test_reset_mid_write;
        logic [7:0] exp_b [4];
        exp_b = '{8'h0D, 8'hF0, 8'h00, 8'h00};
        load_word(8'h40, 32'h00000000);
        @(negedge clk_i);
        core_if.req_i   = 1'b1;
        core_if.we_i    = 1'b1;
        core_if.addr_i  = 32'h40;
        core_if.wdata_i = 32'hCAFEF00D;
        @(posedge clk_i);
        #1;
        core_if.req_i = 1'b0;
        core_if.we_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h42)
            begin errors++; $display("FAIL rst_pre_state: got we=%b a=%h want we=1 a=42", mem_we, mem_addr); end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({core_if.busy_o, core_if.rsp_valid_o, core_if.align_err_o, core_if.byte_we_o,
             core_if.rdata_o, mem_we, mem_addr, mem_wdata} !== 56'd0)
            begin errors++; $display("FAIL rst_async_outputs: outputs nonzero after async reset, required all 0"); end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ram[8'h40 + 8'(k)] !== exp_b[k])
                begin errors++; $display("FAIL rst_ram[%0d]: got %h want %h", k, ram[8'h40 + 8'(k)], exp_b[k]); end
        end
        exp_q.push_back('{rdata: 32'h0000F00D, aerr: 1'b0});
        run_txn(1'b0, 32'h40, 32'h0);
        checks++;
        if (rsp_edge != 5) begin errors++; $display("FAIL rst_next_latency: got %0d want 5", rsp_edge); end
        exp = exp_q.pop_front();
        checks++; if (obs_rdata !== exp.rdata) begin errors++; $display("FAIL rst_next_rdata: got %h want %h", obs_rdata, exp.rdata); end
        last_rd = 32'h0000F00D;
    endtask

    task automatic test_back_to_back_random;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] hi;
        for (int i = 0; i < 4; i++) begin
            hi = $urandom();
            d  = $urandom();
            a  = {hi[31:8], 8'h80 + 8'(i * 4)};
            exp_q.push_back('{rdata: last_rd, aerr: 1'b0});
            run_txn(1'b1, a, d);
            checks++;
            if (rsp_edge != 4) begin errors++; $display("FAIL rnd_wr_latency[%0d]: got %0d want 4", i, rsp_edge); end
            exp = exp_q.pop_front();
            checks++; if (obs_rdata !== exp.rdata) begin errors++; $display("FAIL rnd_wr_rdata[%0d]: got %h want %h", i, obs_rdata, exp.rdata); end
            exp_q.push_back('{rdata: d, aerr: 1'b0});
            run_txn(1'b0, a, 32'h0);
            exp = exp_q.pop_front();
            checks++; if (obs_rdata !== exp.rdata) begin errors++; $display("FAIL rnd_rd_rdata[%0d]: got %h want %h", i, obs_rdata, exp.rdata); end
            checks++; if (obs_aerr !== exp.aerr) begin errors++; $display("FAIL rnd_rd_aerr[%0d]: got %b want %b", i, obs_aerr, exp.aerr); end
            last_rd = d;
        end
    endtask

    initial begin
        core_if.req_i   = 1'b0;
        core_if.we_i    = 1'b0;
        core_if.addr_i  = 32'h0;
        core_if.wdata_i = 32'h0;
        last_rd         = 32'h0;
        test_reset();
        test_read_aligned();
        test_write_then_read();
        test_misaligned();
        test_top_of_memory();
        test_busy_ignore();
        test_reset_mid_write();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
